// File: rtl/datapath_sequencer.sv
// datapath_sequencer: command FIFO and read/execute/write-back sequencer driving the regfile/ALU/buffer datapath
module datapath_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_kind,
  input  logic [7:0]      cmd_alu_op,
  input  logic [3:0]      cmd_dst,
  input  logic [3:0]      cmd_src1,
  input  logic [3:0]      cmd_src2,
  input  logic [15:0]     cmd_imm,
  output logic [15:0]     initialR,
  output logic [3:0]      regWrite,
  output logic [3:0]      regRead1,
  output logic [3:0]      regRead2,
  output logic [7:0]      ALUOp,
  output logic [3:0]      buffCtrl,
  output logic            regWriteEn,
  input  logic [15:0]     alu_result,
  input  logic [4:0]      alu_flags,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [15:0]     resp_result,
  output logic [4:0]      resp_flags,
  output logic            busy,
  output logic [CNTW-1:0] fifo_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef enum logic [2:0] {IDLE, READ, EXEC, LOADI, RESP} state_t;
  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  op;
    logic [3:0]  dst;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [15:0] imm;
  } cmd_t;
  cmd_t          mem [DEPTH];
  cmd_t          ir;
  state_t        state, state_n;
  logic [AW-1:0] wptr, rptr;
  logic          push, pop;
  assign cmd_ready  = !reset && fifo_count < CNTW'(DEPTH);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = state == IDLE && fifo_count != '0;
  assign busy       = state != IDLE || fifo_count != '0;
  assign resp_valid = state == RESP;
  // FIFO storage; entries beyond the occupied window are never read, so no reset
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {cmd_kind, cmd_alu_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm};
  // FIFO pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      fifo_count <= fifo_count + CNTW'(push) - CNTW'(pop);
    end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // instruction register and response capture at the end of EXEC/LOADI
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ir          <= '0;
      resp_result <= '0;
      resp_flags  <= '0;
    end else begin
      if (pop) ir <= mem[rptr];
      if (state == EXEC) begin
        resp_result <= alu_result;
        resp_flags  <= alu_flags;
      end else if (state == LOADI) begin
        resp_result <= ir.imm;
        resp_flags  <= '0;
      end
    end
  // next state and datapath controls decoded purely from state so reset clears them at once
  always_comb begin
    state_n    = state;
    initialR   = '0;
    regWrite   = '0;
    regRead1   = '0;
    regRead2   = '0;
    ALUOp      = '0;
    buffCtrl   = '0;
    regWriteEn = 1'b0;
    case (state)
      IDLE: if (fifo_count != '0) state_n = mem[rptr].kind == 2'd2 ? LOADI : READ;
      READ: begin
        regRead1 = ir.src1;
        regRead2 = ir.src2;
        ALUOp    = ir.op;
        buffCtrl = 4'b0110;
        state_n  = EXEC;
      end
      EXEC: begin
        regRead1   = ir.src1;
        regRead2   = ir.src2;
        ALUOp      = ir.op;
        buffCtrl   = 4'b1110;
        regWrite   = ir.dst;
        regWriteEn = ir.kind == 2'd0;
        state_n    = RESP;
      end
      LOADI: begin
        initialR   = ir.imm;
        buffCtrl   = 4'b0001;
        regWrite   = ir.dst;
        regWriteEn = 1'b1;
        state_n    = RESP;
      end
      RESP: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: scoreboard bench with a behavioural regfile/ALU environment and reference model
module tb_datapath_sequencer;
  logic        clk = 1'b0, reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_kind = '0;
  logic [7:0]  cmd_alu_op = '0;
  logic [3:0]  cmd_dst = '0, cmd_src1 = '0, cmd_src2 = '0;
  logic [15:0] cmd_imm = '0;
  logic [15:0] initialR, alu_result, resp_result, wbus;
  logic [3:0]  regWrite, regRead1, regRead2, buffCtrl;
  logic [7:0]  ALUOp;
  logic        regWriteEn, resp_valid, busy;
  logic        resp_ready = 1'b1;
  logic [4:0]  alu_flags, resp_flags;
  logic [2:0]  fifo_count;
  logic [20:0] alu_out;
  int          errors = 0, checks = 0, rr_mode = 0;
  logic [15:0] env_regs [16] = '{default: '0};
  logic [15:0] ref_regs [16] = '{default: '0};
  logic [20:0] exp_q [$];
  logic [23:0] wr_q [$];
  logic [15:0] obs_q [$];

  datapath_sequencer #(.DEPTH(4), .CNTW(3)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_alu_op(cmd_alu_op), .cmd_dst(cmd_dst),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_imm(cmd_imm),
    .initialR(initialR), .regWrite(regWrite), .regRead1(regRead1), .regRead2(regRead2),
    .ALUOp(ALUOp), .buffCtrl(buffCtrl), .regWriteEn(regWriteEn),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4+ XOR; flags {carry, a<b, low, negative, zero}
  function automatic logic [20:0] alu_f(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = op == 8'd0 ? {1'b0, a} + {1'b0, b} :
        op == 8'd1 ? {1'b0, a} - {1'b0, b} :
        op == 8'd2 ? {1'b0, a & b} :
        op == 8'd3 ? {1'b0, a | b} : {1'b0, a ^ b};
    return {s[16], a < b, s[0], s[15], s[15:0] == 16'd0, s[15:0]};
  endfunction

  always_comb alu_out = alu_f(ALUOp, env_regs[regRead1], env_regs[regRead2]);
  assign alu_result = alu_out[15:0];
  assign alu_flags  = alu_out[20:16];
  assign wbus = buffCtrl[0] ? initialR : buffCtrl[3] ? alu_result : 16'd0;

  always @(posedge clk) if (regWriteEn) env_regs[regWrite] <= wbus;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s", n);
  endtask

  // architectural reference: each accepted command yields one response and possibly one write
  task automatic model(input logic [1:0] k, input logic [7:0] op, input logic [3:0] d,
                       input logic [3:0] s1, input logic [3:0] s2, input logic [15:0] imm);
    logic [20:0] r;
    if (k == 2'd2) begin
      exp_q.push_back({5'd0, imm});
      wr_q.push_back({d, imm, 4'b0001});
      ref_regs[d] = imm;
    end else begin
      r = alu_f(op, ref_regs[s1], ref_regs[s2]);
      exp_q.push_back(r);
      if (k == 2'd0) begin
        wr_q.push_back({d, r[15:0], 4'b1110});
        ref_regs[d] = r[15:0];
      end
    end
  endtask

  task automatic send(input logic [1:0] k, input logic [7:0] op, input logic [3:0] d,
                      input logic [3:0] s1, input logic [3:0] s2, input logic [15:0] imm);
    int n = 0;
    cmd_kind = k; cmd_alu_op = op; cmd_dst = d; cmd_src1 = s1; cmd_src2 = s2; cmd_imm = imm;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) fail("send_timeout");
    else model(k, op, d, s1, s2, imm);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy) fail("drain_timeout");
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_count", 32'(fifo_count), 32'd0);
    chk("writes_done", 32'(wr_q.size()), 32'd0);
  endtask

  task automatic lat_test(input logic [1:0] k, input int exp_n);
    int n = 0;
    cmd_kind = k; cmd_alu_op = 8'd0; cmd_dst = 4'd4; cmd_src1 = 4'd1; cmd_src2 = 4'd2; cmd_imm = 16'h0055;
    cmd_valid = 1'b1;
    model(k, 8'd0, 4'd4, 4'd1, 4'd2, 16'h0055);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!resp_valid && n < 20);
    chk(k == 2'd2 ? "latency_load" : "latency_alu", 32'(n), 32'(exp_n));
    drain();
  endtask

  // response ready pattern: 0 always ready, 1 random, 2 stalled
  initial forever begin
    @(posedge clk);
    #2 resp_ready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // monitor: invariant, write-port and response scoreboard checks
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("imm_alu_clash", 32'(buffCtrl[0] & buffCtrl[3]), 32'd0);
      if (regWriteEn) begin
        if (wr_q.size() == 0) fail("spurious_write");
        else chk("write", 32'({regWrite, wbus, buffCtrl}), 32'(wr_q.pop_front()));
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) fail("spurious_resp");
        else begin
          chk("resp", 32'({resp_flags, resp_result}), 32'(exp_q.pop_front()));
          obs_q.push_back(resp_result);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] saved [16];
    logic [15:0] fib [7] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13};
    int n;
    repeat (3) @(negedge clk);
    chk("rst_datapath", 32'({initialR, regWrite, regRead1, regRead2}), 32'd0);
    chk("rst_ctrl", 32'({ALUOp, buffCtrl, regWriteEn}), 32'd0);
    chk("rst_status", 32'({resp_valid, busy, fifo_count}), 32'd0);
    chk("rst_resp", 32'({resp_flags, resp_result}), 32'd0);
    reset = 1'b0;
    #1 chk("ready_after_rst", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    send(2'd2, 8'd0, 4'd1, 4'd0, 4'd0, 16'h0001);
    drain();
    chk("load_result", 32'({resp_flags, resp_result}), 32'h0001);
    send(2'd2, 8'd0, 4'd2, 4'd0, 4'd0, 16'h0001);
    send(2'd0, 8'd0, 4'd3, 4'd1, 4'd2, 16'h0000);
    drain();
    chk("add_result", 32'(resp_result), 32'h0002);
    send(2'd1, 8'd1, 4'd0, 4'd2, 4'd2, 16'h0000);
    drain();
    chk("cmp_flags", 32'(resp_flags), 32'h01);
    chk("cmp_result", 32'(resp_result), 32'h0000);
    lat_test(2'd2, 2);
    lat_test(2'd0, 3);
    rr_mode = 2;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 7)),
                                     4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    cmd_kind = 2'd2; cmd_dst = 4'd9; cmd_imm = 16'hDEAD; cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_reject", 32'(fifo_count), 32'd4);
    cmd_valid = 1'b0;
    rr_mode = 1;
    drain();
    rr_mode = 0;
    @(negedge clk);
    saved = ref_regs;
    send(2'd0, 8'd0, 4'd5, 4'd1, 4'd2, 16'h0000);
    send(2'd0, 8'd1, 4'd6, 4'd2, 4'd1, 16'h0000);
    send(2'd2, 8'd0, 4'd7, 4'd0, 4'd0, 16'h1234);
    n = 0;
    while (buffCtrl != 4'b1110 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (buffCtrl != 4'b1110) fail("exec_not_seen");
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_we", 32'(regWriteEn), 32'd0);
    chk("rst_mid_buf", 32'(buffCtrl), 32'd0);
    chk("rst_mid_status", 32'({resp_valid, busy, fifo_count}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    wr_q.delete();
    ref_regs = saved;
    @(negedge clk);
    chk("post_rst_idle", 32'({resp_valid, busy, fifo_count}), 32'd0);
    obs_q.delete();
    send(2'd2, 8'd0, 4'd1, 4'd0, 4'd0, 16'h0001);
    send(2'd2, 8'd0, 4'd2, 4'd0, 4'd0, 16'h0001);
    for (int i = 0; i < 5; i++) send(2'd0, 8'd0, i[0] ? 4'd2 : 4'd1, 4'd1, 4'd2, 16'h0000);
    drain();
    chk("fib_len", 32'(obs_q.size()), 32'd7);
    for (int i = 0; i < 7 && i < obs_q.size(); i++) chk("fib_val", 32'(obs_q[i]), 32'(fib[i]));
    rr_mode = 1;
    repeat (80) send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 7)),
                     4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
